// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: rotates an active-low column strobe, samples the
// synchronized rows once per column, classifies each full scan, debounces
// presses and releases, and shifts accepted keys into a four-digit history.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic       clear,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_e;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} result_e;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx_q;
  logic             div_last;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic             res_valid_q, res_valid_d;
  result_e          res_kind_q, res_kind_d;
  logic [3:0]       res_code_q, res_code_d;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             accept;
  logic [3:0]       key_q;
  logic             key_valid_q;
  logic [3:0]       dig_q [4];

  // Hex code printed on the key at row r, column c.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;
      default: key_map = 4'hD;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous row lines.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; a blocking '=' here would collapse the two stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  assign div_last = (div_q == DIV_W'(SCAN_DIV - 1));
  assign col      = ~(4'b0001 << col_idx_q);

  // Column dwell divider and column rotation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
    end else if (div_last) begin
      div_q     <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Per-scan zero counting (saturating at two) and scan classification.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which is what keeps combinational blocks free of latches.
  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    acc_code_d  = acc_code_q;
    res_valid_d = 1'b0;
    res_kind_d  = res_kind_q;
    res_code_d  = res_code_q;
    if (div_last) begin
      if (col_idx_q == 2'd0) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'h0;
      end
      for (int r = 0; r < 4; r++) begin
        if (!row_sync_q[r]) begin
          if (acc_cnt_d == 2'd0) acc_code_d = key_map(2'(r), col_idx_q);
          if (acc_cnt_d != 2'd2) acc_cnt_d = acc_cnt_d + 2'd1;
        end
      end
      if (col_idx_q == 2'd3) begin
        res_valid_d = 1'b1;
        res_code_d  = acc_code_d;
        case (acc_cnt_d)
          2'd0:    res_kind_d = RES_NONE;
          2'd1:    res_kind_d = RES_SINGLE;
          default: res_kind_d = RES_MULTI;
        endcase
      end
    end
  end

  // Scan accumulators and the registered scan result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'h0;
      res_valid_q <= 1'b0;
      res_kind_q  <= RES_NONE;
      res_code_q  <= 4'h0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      res_valid_q <= res_valid_d;
      res_kind_q  <= res_kind_d;
      res_code_q  <= res_code_d;
    end
  end

  // Debounce FSM, advanced once per completed scan.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (res_valid_q) begin
      case (state_q)
        IDLE: begin
          if (res_kind_q == RES_SINGLE) begin
            cand_d = res_code_q;
            cnt_d  = 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_d = HELD;
            end else begin
              state_d = PRESS;
            end
          end
        end
        PRESS: begin
          if (res_kind_q == RES_SINGLE && res_code_q == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else if (res_kind_q == RES_SINGLE) begin
            cand_d = res_code_q;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (res_kind_q == RES_NONE) begin
            cnt_d   = 4'd1;
            state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
          end
        end
        default: begin
          if (res_kind_q == RES_NONE) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == 4'(DEBOUNCE_SCANS)) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= 4'h0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Key output and digit history; clear overrides the shift for the digits only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= 4'h0;
    end else begin
      key_valid_q <= accept;
      if (accept) key_q <= cand_d;
      if (clear) begin
        for (int i = 0; i < 4; i++) dig_q[i] <= 4'h0;
      end else if (accept) begin
        dig_q[3] <= dig_q[2];
        dig_q[2] <= dig_q[1];
        dig_q[1] <= dig_q[0];
        dig_q[0] <= cand_d;
      end
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign dig0      = dig_q[0];
  assign dig1      = dig_q[1];
  assign dig2      = dig_q[2];
  assign dig3      = dig_q[3];

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a matrix keypad model drives the rows from the
// column strobe; accepted keys are checked against a queue of expected codes.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  row, col, key, dig0, dig1, dig2, dig3;
  logic        key_valid;
  logic [15:0] pressed = '0;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int cyc = 0;
  int exp_q[$];

  // Keypad legend indexed by row*4+col.
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'h0, 4'hF, 4'hE, 4'hD};

  typedef struct {
    int r;
    int c;
    int hold;
    int rel;
    bit accept;
    logic [15:0] digs;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset(reset), .row(row), .clear(clear), .col(col),
    .key(key), .key_valid(key_valid),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor plus a global watchdog.
  always @(negedge clk) begin
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL watchdog: got %0d cycles expected < 60000", cyc);
      $fatal(1, "watchdog");
    end
    if (!reset && key_valid) begin
      pulse_cnt++;
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("key", 32'(key), 32'(exp_q.pop_front()));
    end
  end

  // Leaves the bench at the negedge of the first cycle of a new scan.
  task automatic align_scan();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = col;
    for (int i = 0; i < 3 * SCAN; i++) begin
      @(negedge clk);
      if (col == 4'b1110 && prev == 4'b0111) begin
        found = 1'b1;
        break;
      end
      prev = col;
    end
    check("scan_align", 32'(found), 32'd1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int first, p0, idx;
    logic [3:0] ecol;

    tbl[0] = '{r: 0, c: 0, hold: 3, rel: 3, accept: 1'b1, digs: 16'h0051};
    tbl[1] = '{r: 0, c: 1, hold: 3, rel: 3, accept: 1'b1, digs: 16'h0512};
    tbl[2] = '{r: 0, c: 2, hold: 3, rel: 3, accept: 1'b1, digs: 16'h5123};
    tbl[3] = '{r: 0, c: 3, hold: 3, rel: 3, accept: 1'b1, digs: 16'h123A};
    tbl[4] = '{r: 0, c: 0, hold: 1, rel: 3, accept: 1'b0, digs: 16'h123A};
    tbl[5] = '{r: 0, c: 0, hold: 3, rel: 3, accept: 1'b1, digs: 16'h23A1};

    // Reset state, then idle column rotation.
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'h E);
    check("rst_key", 32'(key), 32'h0);
    check("rst_kv", 32'(key_valid), 32'h0);
    check("rst_digs", 32'({dig3, dig2, dig1, dig0}), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      ecol = ~(4'b0001 << ((k / 4) % 4));
      check("col_rot", 32'(col), 32'(ecol));
    end
    check("idle_pulses", 32'(pulse_cnt), 32'd0);
    check("idle_digs", 32'({dig3, dig2, dig1, dig0}), 32'h0);

    // Key 5 held from a scan start: one pulse, 33 cycles in.
    align_scan();
    pressed[5] = 1'b1;
    exp_q.push_back(int'(kmap[5]));
    first = -1;
    p0 = pulse_cnt;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (key_valid && first < 0) first = i;
    end
    check("latency", 32'(first), 32'd33);
    check("single_pulse", 32'(pulse_cnt - p0), 32'd1);
    check("dig0_5", 32'(dig0), 32'h5);
    pressed = '0;
    repeat (3 * SCAN) @(negedge clk);

    // Table: press/release sequences including a one-scan bounce.
    for (int i = 0; i < 6; i++) begin
      align_scan();
      idx = tbl[i].r * 4 + tbl[i].c;
      pressed[idx] = 1'b1;
      if (tbl[i].accept) exp_q.push_back(int'(kmap[idx]));
      repeat (tbl[i].hold * SCAN) @(negedge clk);
      pressed = '0;
      repeat (tbl[i].rel * SCAN) @(negedge clk);
      check("tbl_drain", 32'(exp_q.size()), 32'd0);
      check("tbl_digs", 32'({dig3, dig2, dig1, dig0}), 32'(tbl[i].digs));
    end

    // Two keys together are rejected; releasing one lets the other through.
    align_scan();
    pressed[8]  = 1'b1;
    pressed[15] = 1'b1;
    p0 = pulse_cnt;
    repeat (5 * SCAN) @(negedge clk);
    check("multi_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    pressed[15] = 1'b0;
    exp_q.push_back(int'(kmap[8]));
    wait_drain(4 * SCAN);
    check("multi_digs", 32'({dig3, dig2, dig1, dig0}), 32'h3A17);
    pressed = '0;
    repeat (3 * SCAN) @(negedge clk);

    // Reset mid-PRESS with key 9 held; it must debounce again afterwards.
    align_scan();
    pressed[10] = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_col", 32'(col), 32'hE);
    check("mid_rst_key", 32'(key), 32'h0);
    check("mid_rst_kv", 32'(key_valid), 32'h0);
    check("mid_rst_digs", 32'({dig3, dig2, dig1, dig0}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(int'(kmap[10]));
    wait_drain(4 * SCAN);
    check("post_rst_digs", 32'({dig3, dig2, dig1, dig0}), 32'h0009);
    pressed = '0;
    repeat (3 * SCAN) @(negedge clk);

    // Clear on the same edge as the accept of key 6.
    align_scan();
    pressed[6] = 1'b1;
    exp_q.push_back(int'(kmap[6]));
    repeat (32) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_kv", 32'(key_valid), 32'h1);
    check("clr_key", 32'(key), 32'h6);
    check("clr_digs", 32'({dig3, dig2, dig1, dig0}), 32'h0);
    wait_drain(SCAN);
    pressed = '0;
    repeat (3 * SCAN) @(negedge clk);
    check("final_digs", 32'({dig3, dig2, dig1, dig0}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
